mult_sched: RTL and testbench

Round-robin scheduler that shares the single 32-bit `mult` datapath block among NUM_REQ requesters. Sits between CPU-side functional units (e.g. integer MUL, address scaling) and the multiplier. It launches one operand pair at a time, holds the operands stable for the multicycle window, and returns the truncated product to the requester that was granted.

---
 rtl/mult_sched_pkg.sv | 22 ++
 rtl/mult_sched_mult.sv | 15 +
 rtl/mult_sched.sv | 108 ++++++++++
 tb/tb_mult_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int WORD = 32;

  // Index width for a requester number; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mult_sched_mult.sv
// Registered 32x32 multiplier; the output register is the multicycle-path endpoint.
module mult
  import mult_sched_pkg::*;
(
  input  logic            clock,
  input  logic [WORD-1:0] in1,
  input  logic [WORD-1:0] in2,
  output logic [WORD-1:0] mult_out_reg
);

  always_ff @(posedge clock) begin
    mult_out_reg <= in1 * in2;
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multicycle multiplier among NUM_REQ requesters.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MULT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [WORD*NUM_REQ-1:0] req_in1,
  input  logic [WORD*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [WORD-1:0]         resp_data,
  output logic                    busy
);

  localparam int         IW       = clog2(NUM_REQ);
  localparam logic [3:0] CNT_LAST = 4'(MULT_CYCLES);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [3:0]      cnt;
  logic [WORD-1:0] op1_q;
  logic [WORD-1:0] op2_q;
  logic [WORD-1:0] mult_out_reg;

  // First valid requester strictly after 'last', wrapping; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IW-1:0]      last);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((32'(last) + k) % NUM_REQ);
      if (!res[IW] && valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {win_found, win_idx} = rr_pick(req_valid, ptr);
  end

  // Gated by reset_n so the grant drops the moment reset is asserted.
  always_comb begin
    req_ready = '0;
    if (reset_n && state == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    resp_data = (|resp_valid) ? mult_out_reg : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      gnt_q      <= '0;
      cnt        <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            op1_q <= req_in1[WORD*win_idx +: WORD];
            op2_q <= req_in2[WORD*win_idx +: WORD];
            gnt_q <= win_idx;
            ptr   <= win_idx;
            cnt   <= 4'd1;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            resp_valid        <= '0;
            resp_valid[gnt_q] <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mult u_mult (
    .clock        (clock),
    .in1          (op1_q),
    .in2          (op2_q),
    .mult_out_reg (mult_out_reg)
  );

endmodule

// File: tb/tb_mult_sched.sv
// Randomized self-checking bench for mult_sched against a round-robin reference model.
module tb_mult_sched;

  localparam int NR = 2;
  localparam int MC = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [63:0]   req_in1 = '0;
  logic [63:0]   req_in2 = '0;
  logic [NR-1:0] req_ready, resp_valid, ready1, rv1, ready15, rv15;
  logic [31:0]   resp_data, data1, data15;
  logic          busy, busy1, busy15;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mptr;
  int unsigned cyc = 0;
  int unsigned last_strobe = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  mult_sched #(.NUM_REQ(NR), .MULT_CYCLES(MC)) u_dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_in1(req_in1),
    .req_in2(req_in2), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy));

  mult_sched #(.NUM_REQ(NR), .MULT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_in1(req_in1),
    .req_in2(req_in2), .req_ready(ready1), .resp_valid(rv1),
    .resp_data(data1), .busy(busy1));

  mult_sched #(.NUM_REQ(NR), .MULT_CYCLES(15)) u_dut15 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_in1(req_in1),
    .req_in2(req_in2), .req_ready(ready15), .resp_valid(rv15),
    .resp_data(data15), .busy(busy15));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting index after the last grant, modulo NR.
  function automatic int pick(input logic [NR-1:0] m);
    for (int off = 1; off <= NR; off++) begin
      int i;
      i = (mptr + off) % NR;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  // One transaction on the main DUT; gap > 0 also checks strobe spacing.
  task automatic txn(input logic [NR-1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1, input int gap);
    int          g;
    int          k;
    logic [31:0] ea, eb;
    req_valid = mask;
    req_in1   = {a1, a0};
    req_in2   = {b1, b0};
    #1;
    g = pick(mask);
    if (g < 0) begin
      check("idle_ready", 64'(req_ready), 64'd0);
      @(posedge clock); #1;
      check("idle_busy", 64'(busy), 64'd0);
      return;
    end
    check("grant", 64'(req_ready), 64'd1 << g);
    ea = (g == 0) ? a0 : a1;
    eb = (g == 0) ? b0 : b1;
    @(posedge clock); #1;
    mptr    = g;
    req_in1 = {$urandom, $urandom};
    req_in2 = {$urandom, $urandom};
    check("busy_run", 64'(busy), 64'd1);
    check("ready_run", 64'(req_ready), 64'd0);
    k = 0;
    while (resp_valid == '0 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    check("latency", 64'(k), 64'(MC));
    check("resp_valid", 64'(resp_valid), 64'd1 << g);
    check("resp_data", 64'(resp_data), 64'(prod(ea, eb)));
    if (gap > 0) check("gap", 64'(cyc - last_strobe), 64'(gap));
    last_strobe = cyc;
    @(posedge clock); #1;
    check("strobe_len", 64'(resp_valid), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    check("data_gated", 64'(resp_data), 64'd0);
  endtask

  initial begin
    int strobes;
    int k1, k15;
    logic [31:0] d1, d15;

    // Reset state with requests already pending.
    req_valid = '1;
    req_in1   = {32'd5, 32'd9};
    req_in2   = {32'd2, 32'd3};
    #2;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clock); @(posedge clock); #2;
    req_valid = '0;
    reset_n   = 1'b1;
    mptr      = NR - 1;

    txn(2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 0);
    txn(2'b10, 32'd1, 32'd1, 32'hFFFF_FFFD, 32'd5, 0);
    check("signed_const", 64'(prod(32'hFFFF_FFFD, 32'd5)), 64'h0000_0000_FFFF_FFF1);
    txn(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 0);
    txn(2'b10, 32'd0, 32'd0, 32'h0001_FFFF, 32'h0001_0001, 0);

    // Abort a request mid-RUN with reset; both requesters stay valid throughout.
    req_valid = 2'b11;
    req_in1   = {32'd11, 32'd13};
    req_in2   = {32'd17, 32'd19};
    @(posedge clock); #1;
    check("pre_abort_busy", 64'(busy), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd0);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    strobes = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      if (resp_valid != '0) strobes++;
    end
    req_valid = '0;
    #2 reset_n = 1'b1;
    mptr = NR - 1;
    for (int i = 0; i < MC + 3; i++) begin
      @(posedge clock); #1;
      if (resp_valid != '0) strobes++;
    end
    check("abort_no_strobe", 64'(strobes), 64'd0);

    // Both requesters held valid: grants alternate from 0, strobes MC+2 apart.
    for (int i = 0; i < 4; i++)
      txn(2'b11, $urandom, $urandom, $urandom, $urandom, (i == 0) ? 0 : MC + 2);

    for (int i = 0; i < 30; i++)
      txn(NR'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, 0);

    // Extreme MULT_CYCLES builds: single 3*4 request from a fresh reset.
    reset_n = 1'b0;
    req_valid = '0;
    #10;
    reset_n = 1'b1;
    @(posedge clock); #1;
    req_valid = 2'b01;
    req_in1   = {32'd0, 32'd3};
    req_in2   = {32'd0, 32'd4};
    #1;
    check("mc1_grant", 64'(ready1), 64'd1);
    check("mc15_grant", 64'(ready15), 64'd1);
    @(posedge clock); #1;
    req_valid = '0;
    k1 = -1; k15 = -1; d1 = '0; d15 = '0;
    for (int k = 0; k <= 20; k++) begin
      if (rv1 != '0 && k1 < 0) begin k1 = k; d1 = data1; end
      if (rv15 != '0 && k15 < 0) begin k15 = k; d15 = data15; end
      @(posedge clock); #1;
    end
    check("mc1_latency", 64'(k1), 64'd1);
    check("mc1_data", 64'(d1), 64'd12);
    check("mc15_latency", 64'(k15), 64'd15);
    check("mc15_data", 64'(d15), 64'd12);
    check("mc15_idle", 64'(busy15), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
